score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_keeper.sv | 169 ++++++++++++++++
 tb/tb_score_keeper.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Purpose: game score/state tracker with animation clock divider and high-score register.
// Latency: one clock from START/PASS/HIT to STATE/SCORE; BCD settles 11 clocks after a SCORE change.
// Backpressure: none; PASS/HIT are single-cycle pulses sampled every clock.
//
// Ports:
//   CLOCK_50  - sole clock
//   RESETN    - asynchronous active-low reset
//   START     - level, begins a game from IDLE
//   PASS/HIT  - one-cycle pulses: obstacle cleared / collision
//   ANIMCLK   - divided animation clock, held low in OVER
//   SCORE     - current score (saturates at MAX_SCORE)
//   HISCORE   - best score since reset
//   STATE     - 00 IDLE, 01 RUN, 10 OVER
//   BCD       - SCORE as three BCD digits (only with SCORE_BCD_EN)
//   BCD_VALID - BCD matches SCORE (only with SCORE_BCD_EN)
// Optional feature: define SCORE_BCD_EN to build the sequential double-dabble converter.
module score_keeper #(
  parameter int CLK_HZ    = 50000000,
  parameter int ANIM_HZ   = 60,
  parameter int MAX_SCORE = 999,
  parameter int OVER_HOLD = 120
) (
  input  logic        CLOCK_50,
  input  logic        RESETN,
  input  logic        START,
  input  logic        PASS,
  input  logic        HIT,
  output logic        ANIMCLK,
  output logic [9:0]  SCORE,
  output logic [9:0]  HISCORE,
  output logic [1:0]  STATE,
  output logic [11:0] BCD,
  output logic        BCD_VALID
);

  localparam int DIV = CLK_HZ / (2 * ANIM_HZ);
  localparam int CW  = ($clog2(DIV) > 20) ? $clog2(DIV) : 20;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam int HW  = (OVER_HOLD > 1) ? $clog2(OVER_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(OVER_HOLD - 1);
  localparam logic [9:0] SCORE_MAX = 10'(MAX_SCORE);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   div_cnt;
  logic            phase, phase_nxt;
  logic            div_tick, anim_tick;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [9:0]      score_nxt, hiscore_nxt;

  // Divider runs regardless of game state; an animation tick is the edge
  // on which the phase rises.
  assign div_tick  = (div_cnt == DIV_LAST);
  assign phase_nxt = phase ^ div_tick;
  assign anim_tick = div_tick & ~phase;

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      div_cnt <= div_tick ? '0 : div_cnt + CW'(1);
      phase   <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    score_nxt   = SCORE;
    hiscore_nxt = HISCORE;
    hold_nxt    = hold_cnt;
    case (state)
      IDLE: begin
        if (START) begin
          state_nxt = RUN;
          score_nxt = '0;
        end
      end
      RUN: begin
        // HIT has priority over a simultaneous PASS.
        if (HIT) begin
          state_nxt = OVER;
          hold_nxt  = '0;
          if (SCORE > HISCORE) hiscore_nxt = SCORE;
        end else if (PASS && (SCORE < SCORE_MAX)) begin
          score_nxt = SCORE + 10'd1;
        end
      end
      OVER: begin
        if (anim_tick) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt = IDLE;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + HW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      state    <= IDLE;
      SCORE    <= '0;
      HISCORE  <= '0;
      hold_cnt <= '0;
      ANIMCLK  <= 1'b0;
    end else begin
      state    <= state_nxt;
      SCORE    <= score_nxt;
      HISCORE  <= hiscore_nxt;
      hold_cnt <= hold_nxt;
      // Registered copy of the phase, computed from next-state values so it
      // tracks the phase exactly and drops on the same edge OVER is entered.
      ANIMCLK  <= (state_nxt != OVER) & phase_nxt;
    end
  end

  assign STATE = state;

`ifdef SCORE_BCD_EN
  logic [9:0]  bcd_src;
  logic [21:0] dd_sh, dd_adj, dd_step;
  logic [3:0]  dd_cnt;

  // One double-dabble iteration: add 3 to any digit >= 5, then shift left.
  always_comb begin
    dd_adj = dd_sh;
    for (int i = 0; i < 3; i++) begin
      if (dd_sh[10+4*i +: 4] >= 4'd5) dd_adj[10+4*i +: 4] = dd_sh[10+4*i +: 4] + 4'd3;
    end
    dd_step = dd_adj << 1;
  end

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      bcd_src   <= '0;
      dd_sh     <= '0;
      dd_cnt    <= '0;
      BCD       <= '0;
      BCD_VALID <= 1'b1;
    end else if (SCORE != bcd_src) begin
      // Any SCORE change (including mid-conversion) restarts the conversion.
      bcd_src   <= SCORE;
      dd_sh     <= {12'd0, SCORE};
      dd_cnt    <= 4'd10;
      BCD_VALID <= 1'b0;
    end else if (dd_cnt != 4'd0) begin
      dd_sh  <= dd_step;
      dd_cnt <= dd_cnt - 4'd1;
      if (dd_cnt == 4'd1) begin
        BCD       <= dd_step[21:10];
        BCD_VALID <= 1'b1;
      end
    end
  end
`else
  assign BCD       = '0;
  assign BCD_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  localparam int CLK_HZ    = 1200;
  localparam int ANIM_HZ   = 60;
  localparam int MAX_SCORE = 5;
  localparam int OVER_HOLD = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pass  = 1'b0;
  logic        hit   = 1'b0;
  logic        animclk;
  logic [9:0]  score, hiscore;
  logic [1:0]  state;
  logic [11:0] bcd;
  logic        bcd_valid;

  score_keeper #(
    .CLK_HZ(CLK_HZ), .ANIM_HZ(ANIM_HZ), .MAX_SCORE(MAX_SCORE), .OVER_HOLD(OVER_HOLD)
  ) dut (
    .CLOCK_50(clk), .RESETN(rst_n), .START(start), .PASS(pass), .HIT(hit),
    .ANIMCLK(animclk), .SCORE(score), .HISCORE(hiscore), .STATE(state),
    .BCD(bcd), .BCD_VALID(bcd_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: edges since reset release, expected state/score/hiscore.
  int         n = 0;
  logic [1:0] m_state = 2'd0;
  logic [9:0] m_score = 10'd0;
  logic [9:0] m_hi    = 10'd0;
  int         m_ticks = 0;

  // Scoreboard of expected {state, score, hiscore, animclk} per driven cycle.
  string       tag_q[$];
  logic [22:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Drive one clock of stimulus, predict the outcome, then compare.
  task automatic cyc(input string tag, input logic s, input logic p, input logic h);
    int          nn;
    logic        tick, ea;
    string       t;
    logic [22:0] e;
    start = s; pass = p; hit = h;
    nn   = n + 1;
    tick = ((nn % 20) == 10);
    case (m_state)
      2'd0: if (s) begin m_state = 2'd1; m_score = 10'd0; end
      2'd1: begin
        if (h) begin
          m_state = 2'd2;
          if (m_score > m_hi) m_hi = m_score;
          m_ticks = 0;
        end else if (p && (m_score < MAX_SCORE)) begin
          m_score = m_score + 10'd1;
        end
      end
      default: begin
        if (tick) begin
          m_ticks++;
          if (m_ticks == OVER_HOLD) m_state = 2'd0;
        end
      end
    endcase
    ea = (m_state != 2'd2) && (((nn / 10) % 2) == 1);
    tag_q.push_back(tag);
    exp_q.push_back({m_state, m_score, m_hi, ea});
    step();
    n = nn;
    start = 1'b0; pass = 1'b0; hit = 1'b0;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    chk({t, ".state"},   state,   e[22:21]);
    chk({t, ".score"},   score,   e[20:11]);
    chk({t, ".hiscore"}, hiscore, e[10:1]);
    chk({t, ".animclk"}, animclk, e[0]);
  endtask

  task automatic wait_bcd(input bit changed);
`ifdef SCORE_BCD_EN
    int k;
    cyc("bcd_gap", 1'b0, 1'b0, 1'b0);
    if (changed) chk("bcd_drop", bcd_valid, 0);
    k = 0;
    while ((bcd_valid !== 1'b1) && (k < 11)) begin
      cyc("bcd_wait", 1'b0, 1'b0, 1'b0);
      k++;
    end
    chk("bcd_valid", bcd_valid, 1);
    chk("bcd_value", bcd, to_bcd(int'(m_score)));
`else
    cyc("bcd_gap", 1'b0, 1'b0, 1'b0);
    chk(changed ? "bcd_off_chg" : "bcd_off_same", bcd, 0);
    chk("bcd_valid_off", bcd_valid, 0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".state"},   state,   0);
    chk({tag, ".score"},   score,   0);
    chk({tag, ".hiscore"}, hiscore, 0);
    chk({tag, ".animclk"}, animclk, 0);
    chk({tag, ".bcd"},     bcd,     0);
`ifdef SCORE_BCD_EN
    chk({tag, ".bcd_valid"}, bcd_valid, 1);
`else
    chk({tag, ".bcd_valid"}, bcd_valid, 0);
`endif
  endtask

  task automatic release_reset();
    step();
    rst_n = 1'b1;
    n = 0; m_state = 2'd0; m_score = 10'd0; m_hi = 10'd0; m_ticks = 0;
  endtask

  task automatic idle_run(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      cyc("div", 1'b0, 1'b0, 1'b0);
      if (n == 9)  chk("div_pre_rise", animclk, 0);
      if (n == 10) chk("div_first_rise", animclk, 1);
      if (n == 20) chk("div_first_fall", animclk, 0);
    end
  endtask

  initial begin
    int k;
    bit ch;

    // Power-on reset
    repeat (3) step();
    check_reset_outputs("por");
    release_reset();

    // Divider in IDLE
    idle_run(25);

    // Game 1: reach 4, then reset mid-RUN
    cyc("g1_start", 1'b1, 1'b0, 1'b0);
    chk("g1_run", state, 2'b01);
    for (int i = 0; i < 4; i++) cyc("g1_pass", 1'b0, 1'b1, 1'b0);
    chk("g1_score4", score, 4);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midrun_rst");
    step();
    release_reset();

    // Divider restarts from 0 after release
    idle_run(22);

    // Game 2: score 3, then PASS and HIT together
    cyc("g2_start", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("g2_pass", 1'b0, 1'b1, 1'b0);
    cyc("g2_hit", 1'b0, 1'b1, 1'b1);
    chk("g2_over",    state,   2'b10);
    chk("g2_score",   score,   3);
    chk("g2_hiscore", hiscore, 3);
    chk("g2_animclk", animclk, 0);
    // START/PASS/HIT in OVER are ignored; START stays high to restart on IDLE
    cyc("over_ign", 1'b1, 1'b1, 1'b1);
    k = 0;
    while ((m_state == 2'd2) && (k < 200)) begin
      cyc("over_hold", 1'b1, 1'b0, 1'b0);
      k++;
    end
    chk("over_to_idle", state, 2'b00);
    chk("idle_score_held", score, 3);
    cyc("restart_held", 1'b1, 1'b0, 1'b0);
    chk("restart_run", state, 2'b01);
    chk("restart_score0", score, 0);

    // Game 3 (continuing): ends at 2, high score unchanged
    for (int i = 0; i < 2; i++) cyc("g3_pass", 1'b0, 1'b1, 1'b0);
    cyc("g3_hit", 1'b0, 1'b0, 1'b1);
    chk("g3_hiscore_kept", hiscore, 3);
    cyc("g3_start_ign", 1'b1, 1'b0, 1'b0);
    chk("g3_start_ignored", state, 2'b10);
    k = 0;
    while ((m_state == 2'd2) && (k < 200)) begin
      cyc("g3_hold", 1'b0, 1'b0, 1'b0);
      k++;
    end
    cyc("idle_ign", 1'b0, 1'b1, 1'b1);
    chk("idle_ign_score", score, 2);
    chk("idle_ign_state", state, 2'b00);

    // Game 4: saturation at MAX_SCORE with BCD tracking
    cyc("g4_start", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      ch = (m_score < MAX_SCORE);
      cyc("g4_pass", 1'b0, 1'b1, 1'b0);
      wait_bcd(ch);
    end
    chk("g4_saturated", score, 5);
`ifdef SCORE_BCD_EN
    chk("g4_bcd005", bcd, 12'h005);
    chk("g4_bcd_valid", bcd_valid, 1);
`else
    chk("g4_bcd_tied", bcd, 0);
    chk("g4_bcd_valid_tied", bcd_valid, 0);
`endif
    cyc("g4_hit", 1'b0, 1'b0, 1'b1);
    chk("g4_hiscore5", hiscore, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
